cmd_arbiter_5b: RTL
===================

# cmd_arbiter_5b

Five-source command arbiter for the command scheduler. It picks one of five requesting command sources per cycle and loads the winner's payload into a single registered output slot, which drains to the DRAM command bus through a valid/ready handshake. Priority selection follows the 5-bit one-hot encoder scheme. A per-source holdoff timer enforces a minimum spacing between grants to the same source. An issue-enable input gates all arbitration.

## Interface
- DATA_W, 32, payload width per source.
- HOLD_CYC, 2, cycles a source stays ineligible after each of its grants. 0 disables holdoff.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  5  per-source request valid.
- req_data  in  5*DATA_W  payloads; source i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  5  one-hot grant; acceptance happens when req_valid[i] & req_ready[i].
- arb_en  in  1  issue enable. When 0, no grants are made.
- flush  in  1  drops the output slot and clears all holdoff counters.
- cmd_valid  out  1  output slot full.
- cmd_data  out  DATA_W  registered winner payload.
- cmd_src  out  5  one-hot index of the winning source.
- cmd_ready  in  1  downstream accept.

## Operation
- Slot FSM has two states: EMPTY (cmd_valid=0) and FULL (cmd_valid=1).
- load_ok = EMPTY | (FULL & cmd_ready).
- elig[i] = req_valid[i] & (hold_cnt[i]==0) & arb_en & load_ok & ~flush.
- Winner selection:
  - The winner is the first set bit of elig, scanning from the current priority pointer upward with wrap 4→0.
  - req_ready is the one-hot winner, or 0 if elig==0.
  - req_ready is combinational from the inputs and current state.
  - req_ready never asserts for a source whose req_valid=0.
- On a grant to source w:
  - cmd_data ← req_data[w]; cmd_src ← 1<<w; slot becomes FULL.
  - hold_cnt[w] ← HOLD_CYC.
  - Pointer ← (w+1) mod 5 when round-robin is compiled in (see Configuration).
- Slot transitions without a grant:
  - FULL & cmd_ready → EMPTY.
  - FULL & ~cmd_ready → FULL. cmd_data and cmd_src are held stable.
- Holdoff counters:
  - Each counter is $clog2(HOLD_CYC+1) bits wide, minimum 1.
  - A nonzero counter decrements by 1 per cycle, saturating at 0.
  - Reload on grant takes precedence over decrement.
- flush:
  - Same cycle: no grant.
  - Next cycle: cmd_valid=0 and all hold_cnt=0.
  - The pointer is unchanged.
  - flush overrides a simultaneous cmd_ready; the transfer is considered lost.

## Timing
- Reset values: cmd_valid=0, cmd_data=0, cmd_src=0, every hold_cnt=0, pointer=0 (source 0 highest). req_ready=0 during reset.
- Latency: a request accepted at edge N appears on cmd_valid/cmd_data at cycle N+1.
- Throughput: one command per cycle while cmd_ready=1 and eligible sources exist. A slot draining and reloading in the same cycle is required.
- Holdoff: a source granted at edge N is ineligible in cycles N+1 through N+HOLD_CYC and eligible from cycle N+HOLD_CYC+1.
- Backpressure: with FULL & ~cmd_ready, req_ready=0 for all sources, and the requesters hold their data.
- arb_en falling mid-burst: an already-loaded slot still drains. No new grant is made.
- Reset mid-transfer: the slot content is discarded with no partial handshake.
- All sources held off: req_ready=0, with no deadlock; grants resume when the counters expire.

## Configuration
- CMD_ARB_RR_EN defined: rotating priority; the pointer advances to winner+1 on each grant.
- CMD_ARB_RR_EN undefined:
  - Fixed priority, lowest index wins.
  - The pointer register is removed and the scan always starts at 0.
  - Holdoff still applies.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with all req_valid=1 → cmd_valid=0, req_ready=0, cmd_src=0. First grant after reset goes to source 0.
- RR fairness (CMD_ARB_RR_EN, HOLD_CYC=0): req_valid=5'b11111, cmd_ready=1 → cmd_src sequence 00001, 00010, 00100, 01000, 10000, 00001, one per cycle.
- Fixed priority (macro undefined, HOLD_CYC=0): req_valid=5'b10110 → source 1 is granted every cycle; source 4 is never granted.
- Holdoff (HOLD_CYC=2): only source 3 valid, cmd_ready=1 → grants at cycles 0, 3, 6; req_ready[3]=0 in cycles 1, 2, 4, 5.
- Backpressure: grant source 2 with payload 0xA5A5_0002, then hold cmd_ready=0 for 4 cycles → cmd_data stays 0xA5A5_0002 and req_ready=0 throughout. When cmd_ready rises, the next grant loads in that same cycle.
- Flush: slot FULL with cmd_ready=1 and flush=1 in the same cycle → no req_ready. Next cycle cmd_valid=0 and all counters are 0.

Source files
------------

// File: rtl/cmd_arbiter_5b_if.sv
// Command arbiter bus bundle: five request sources in, one registered command slot out.
interface cmd_arbiter_5b_if #(
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned N_SRC = 5;

  logic [N_SRC-1:0]        req_valid;
  logic [N_SRC*DATA_W-1:0] req_data;
  logic [N_SRC-1:0]        req_ready;
  logic                    arb_en;
  logic                    flush;
  logic                    cmd_valid;
  logic [DATA_W-1:0]       cmd_data;
  logic [N_SRC-1:0]        cmd_src;
  logic                    cmd_ready;

  // Arbiter side
  modport slave (
    input  req_valid, req_data, arb_en, flush, cmd_ready,
    output req_ready, cmd_valid, cmd_data, cmd_src
  );

  // Requester / downstream side
  modport master (
    output req_valid, req_data, arb_en, flush, cmd_ready,
    input  req_ready, cmd_valid, cmd_data, cmd_src
  );
endinterface

// File: rtl/cmd_arbiter_5b.sv
// Five-source command arbiter feeding one registered output slot.
// Per-source holdoff timers enforce spacing between grants to the same source.
// Optional feature: define CMD_ARB_RR_EN for rotating priority; otherwise fixed
// priority with source 0 highest.
module cmd_arbiter_5b #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned HOLD_CYC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  cmd_arbiter_5b_if.slave bus
);

  localparam int unsigned N_SRC = 5;
  localparam int unsigned CNT_W = (HOLD_CYC == 0) ? 1 : $clog2(HOLD_CYC + 1);
  localparam int unsigned PTR_W = 3;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]                  state_q, state_d;
  logic [DATA_W-1:0]           data_q, data_d;
  logic [N_SRC-1:0]            src_q, src_d;
  logic [N_SRC-1:0][CNT_W-1:0] hold_q, hold_d;

  logic [N_SRC-1:0] elig;
  logic [N_SRC-1:0] grant;
  logic [PTR_W-1:0] win_idx;
  logic [PTR_W-1:0] scan_base;
  logic             load_ok;

`ifdef CMD_ARB_RR_EN
  logic [PTR_W-1:0] ptr_q, ptr_d;
  assign scan_base = ptr_q;
`else
  assign scan_base = '0;
`endif

  // Eligibility and rotating/fixed scan for the winner
  always_comb begin
    load_ok = (state_q == ST_EMPTY) | bus.cmd_ready;
    elig    = '0;
    grant   = '0;
    win_idx = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      elig[i] = bus.req_valid[i] & (hold_q[i] == '0) & bus.arb_en & load_ok
                & ~bus.flush & rst_n;
    end
    for (int k = 0; k < int'(N_SRC); k++) begin
      int unsigned idx;
      idx = 32'(scan_base) + 32'(k);
      if (idx >= N_SRC) idx = idx - N_SRC;
      if ((grant == '0) && elig[idx]) begin
        grant[idx] = 1'b1;
        win_idx    = PTR_W'(idx);
      end
    end
  end

  // Slot, holdoff and pointer next-state
  always_comb begin
    int unsigned win_base;
    state_d  = state_q;
    data_d   = data_q;
    src_d    = src_q;
    hold_d   = hold_q;
    win_base = 32'(win_idx) * DATA_W;
`ifdef CMD_ARB_RR_EN
    ptr_d    = ptr_q;
`endif

    for (int i = 0; i < int'(N_SRC); i++) begin
      if (hold_q[i] != '0) hold_d[i] = hold_q[i] - CNT_W'(1);
      if (grant[i])        hold_d[i] = CNT_W'(HOLD_CYC);
    end

    case (state_q)
      ST_EMPTY: begin
        if (grant != '0) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (grant == '0 && bus.cmd_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase

    if (grant != '0) begin
      data_d = bus.req_data[win_base +: DATA_W];
      src_d  = grant;
`ifdef CMD_ARB_RR_EN
      ptr_d  = (win_idx == PTR_W'(N_SRC - 1)) ? '0 : win_idx + PTR_W'(1);
`endif
    end

    // Flush drops the slot (even mid-handshake) and clears every timer
    if (bus.flush) begin
      state_d = ST_EMPTY;
      hold_d  = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      hold_q  <= '0;
`ifdef CMD_ARB_RR_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      hold_q  <= hold_d;
`ifdef CMD_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign bus.req_ready = grant;
  assign bus.cmd_valid = (state_q == ST_FULL);
  assign bus.cmd_data  = data_q;
  assign bus.cmd_src   = src_q;

endmodule
